// File: rtl/mmio_device_hub.sv
// mmio_device_hub: memory-mapped bridge between the CPU data port and data memory.
// A small window of DATA/STATUS word pairs fronts NUM_DEV device channels. Each channel
// queues command words in a FIFO and hands them to its device one at a time with a
// start pulse, tracking busy/done/overflow for polling or interrupt use.
`timescale 1ns/1ps
module mmio_device_hub #(
  parameter int                NUM_DEV   = 4,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                QDEPTH    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000FFC0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  input  logic                        cpu_read,
  input  logic                        cpu_write,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_DEV-1:0]          dev_start,
  output logic [NUM_DEV*DATA_W-1:0]   dev_data,
  input  logic [NUM_DEV-1:0]          dev_finish,
  output logic                        irq
);

  // Pointer width wraps naturally because QDEPTH is a power of two; the count needs
  // one extra bit so that a completely full FIFO (QDEPTH entries) is representable.
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  // Address decode results
  logic [NUM_DEV-1:0] hit_data;
  logic [NUM_DEV-1:0] hit_status;
  logic               hit;

  // Channel FSM
  state_t state_q [NUM_DEV];
  state_t state_d [NUM_DEV];

  // Per-channel FIFO storage and bookkeeping
  logic [DATA_W-1:0] fifo_q  [NUM_DEV][QDEPTH];
  logic [DATA_W-1:0] fifo_d  [NUM_DEV][QDEPTH];
  logic [PW-1:0]     wptr_q  [NUM_DEV];
  logic [PW-1:0]     wptr_d  [NUM_DEV];
  logic [PW-1:0]     rptr_q  [NUM_DEV];
  logic [PW-1:0]     rptr_d  [NUM_DEV];
  logic [CW-1:0]     count_q [NUM_DEV];
  logic [CW-1:0]     count_d [NUM_DEV];

  // Last dispatched command word per channel
  logic [DATA_W-1:0] dev_data_q [NUM_DEV];
  logic [DATA_W-1:0] dev_data_d [NUM_DEV];

  // Sticky flags and interrupt enables
  logic [NUM_DEV-1:0] done_q;
  logic [NUM_DEV-1:0] done_d;
  logic [NUM_DEV-1:0] ovf_q;
  logic [NUM_DEV-1:0] ovf_d;
  logic [NUM_DEV-1:0] irq_en_q;
  logic [NUM_DEV-1:0] irq_en_d;

  // FSM-derived per-channel strobes
  logic [NUM_DEV-1:0] start_w;
  logic [NUM_DEV-1:0] finish_w;
  logic [DATA_W-1:0]  head_w   [NUM_DEV];
  logic [DATA_W-1:0]  status_w [NUM_DEV];

  // Decode the CPU address against every channel's DATA and STATUS word
  always_comb begin
    hit_data   = '0;
    hit_status = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      hit_data[i]   = (cpu_addr == BASE_ADDR + ADDR_W'(8 * i));
      hit_status[i] = (cpu_addr == BASE_ADDR + ADDR_W'(8 * i + 4));
    end
    hit = (|hit_data) | (|hit_status);
  end

  // Assemble the STATUS word of each channel from live state
  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) begin
      status_w[i]       = '0;
      status_w[i][0]    = (state_q[i] != S_IDLE);
      status_w[i][1]    = (count_q[i] == CW'(QDEPTH));
      status_w[i][2]    = (count_q[i] == '0);
      status_w[i][3]    = ovf_q[i];
      status_w[i][4]    = done_q[i];
      status_w[i][5]    = irq_en_q[i];
      status_w[i][15:8] = 8'(count_q[i]);
    end
  end

  // Gate memory strobes and select the load data returned to the CPU
  always_comb begin
    mem_read  = cpu_read  & ~hit;
    mem_write = cpu_write & ~hit;
    cpu_rdata = mem_rdata;
    if (hit) begin
      cpu_rdata = '0;
    end
    for (int i = 0; i < NUM_DEV; i++) begin
      if (hit_status[i]) begin
        cpu_rdata = status_w[i];
      end
    end
  end

  // Channel FSM state register
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DEV; i++) begin
      if (!rst_n) begin
        state_q[i] <= S_IDLE;
      end else begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Channel FSM next-state: dispatch when work is queued, wait for the device to finish
  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:  if (count_q[i] != '0) state_d[i] = S_START;
        S_START: state_d[i] = S_BUSY;
        S_BUSY:  if (dev_finish[i])    state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Channel FSM outputs: start pulse, accepted finish, and the command word presented
  always_comb begin
    start_w  = '0;
    finish_w = '0;
    dev_data = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      head_w[i]   = fifo_q[i][rptr_q[i]];
      start_w[i]  = (state_q[i] == S_START);
      // A finish arriving during START belongs to no command and is dropped.
      finish_w[i] = (state_q[i] == S_BUSY) & dev_finish[i];
      dev_data[i*DATA_W +: DATA_W] = start_w[i] ? head_w[i] : dev_data_q[i];
    end
    dev_start = start_w;
  end

  // Next-state for FIFOs, captured command words and status flags
  always_comb begin
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    dev_data_d = dev_data_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    irq_en_d   = irq_en_q;
    for (int i = 0; i < NUM_DEV; i++) begin
      logic store_data;
      logic store_stat;
      logic full;
      logic push;
      store_data = cpu_write & hit_data[i];
      store_stat = cpu_write & hit_status[i];
      // Fullness is judged on the registered count, so a pop in the same cycle
      // does not make room for a store that arrives on a full FIFO.
      full       = (count_q[i] == CW'(QDEPTH));
      push       = store_data & ~full;

      if (push) begin
        fifo_d[i][wptr_q[i]] = cpu_wdata;
        wptr_d[i]            = wptr_q[i] + 1'b1;
      end
      if (start_w[i]) begin
        rptr_d[i]     = rptr_q[i] + 1'b1;
        dev_data_d[i] = head_w[i];
      end
      count_d[i] = count_q[i] + CW'(push) - CW'(start_w[i]);

      ovf_d[i]  = (ovf_q[i] & ~(store_stat & cpu_wdata[3])) | (store_data & full);
      // Hardware completion wins over a software clear in the same cycle.
      done_d[i] = (done_q[i] & ~(store_stat & cpu_wdata[4])) | finish_w[i];
      if (store_stat) begin
        irq_en_d[i] = cpu_wdata[5];
      end
    end
  end

  // FIFO storage: contents are don't-care once the pointers are reset
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // Control registers: pointers, counts, flags and the held command words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        wptr_q[i]     <= '0;
        rptr_q[i]     <= '0;
        count_q[i]    <= '0;
        dev_data_q[i] <= '0;
      end
      done_q   <= '0;
      ovf_q    <= '0;
      irq_en_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      dev_data_q <= dev_data_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
    end
  end

  assign irq = |(done_q & irq_en_q);

endmodule

// File: tb/tb_mmio_device_hub.sv
// Testbench for mmio_device_hub: a vector table for decode, pass-through and single
// dispatch, then directed sequences for overflow, interrupts, interleaved channels
// with pointer wrap, and reset in the middle of a transaction.
`timescale 1ns/1ps
module tb_mmio_device_hub;

  localparam int NDEV = 4;
  localparam logic [31:0] BASE = 32'h0000FFC0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic              cpu_read = 1'b0;
  logic              cpu_write = 1'b0;
  logic [31:0]       cpu_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata = '0;
  logic [NDEV-1:0]   dev_start;
  logic [NDEV*32-1:0] dev_data;
  logic [NDEV-1:0]   dev_finish = '0;
  logic              irq;

  int checks = 0;
  int failures = 0;

  mmio_device_hub #(
    .NUM_DEV(NDEV), .DATA_W(32), .ADDR_W(32), .QDEPTH(4), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .dev_start(dev_start), .dev_data(dev_data), .dev_finish(dev_finish),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [31:0] mrd;
    logic [3:0]  fin;
    logic [31:0] e_rdata;
    logic        e_mr;
    logic        e_mw;
    logic [3:0]  e_start;
    logic [31:0] e_dd0;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = 1'b1;
    cyc();
    cpu_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    cpu_addr = a;
    cpu_read = 1'b1;
    #1;
    d = cpu_rdata;
    cpu_read = 1'b0;
  endtask

  logic [31:0] rv;
  logic [31:0] q0[$];
  logic [31:0] q3[$];
  int t0, t3, n0, n3, spur, k;

  initial begin
    // addr, wdata, rd, wr, mem_rdata, finish | rdata, mem_read, mem_write, start, dev_data[31:0]
    vecs[0]  = '{32'h100,   32'h0,  1'b1, 1'b0, 32'hDEADBEEF, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0, 4'h0, 32'h0};
    vecs[1]  = '{32'h100,   32'h55, 1'b0, 1'b1, 32'h12345678, 4'h0, 32'h12345678, 1'b0, 1'b1, 4'h0, 32'h0};
    vecs[2]  = '{32'hFFC4,  32'h0,  1'b1, 1'b0, 32'hCAFEF00D, 4'h0, 32'h00000004, 1'b0, 1'b0, 4'h0, 32'h0};
    vecs[3]  = '{32'hFFC0,  32'hA5, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0};
    vecs[4]  = '{32'hFFC4,  32'h0,  1'b1, 1'b0, 32'h0,        4'h0, 32'h00000100, 1'b0, 1'b0, 4'h0, 32'h0};
    vecs[5]  = '{32'h100,   32'h0,  1'b1, 1'b0, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 4'h1, 32'hA5};
    vecs[6]  = '{32'hFFC4,  32'h0,  1'b1, 1'b0, 32'h0,        4'h0, 32'h00000005, 1'b0, 1'b0, 4'h0, 32'hA5};
    vecs[7]  = '{32'h100,   32'h0,  1'b0, 1'b0, 32'h0,        4'h1, 32'h0,        1'b0, 1'b0, 4'h0, 32'hA5};
    vecs[8]  = '{32'hFFC4,  32'h0,  1'b1, 1'b0, 32'h0,        4'h0, 32'h00000014, 1'b0, 1'b0, 4'h0, 32'hA5};
    vecs[9]  = '{32'hFFC4,  32'h10, 1'b0, 1'b1, 32'h0,        4'h0, 32'h00000014, 1'b0, 1'b0, 4'h0, 32'hA5};
    vecs[10] = '{32'hFFC4,  32'h0,  1'b1, 1'b0, 32'h0,        4'h0, 32'h00000004, 1'b0, 1'b0, 4'h0, 32'hA5};
    vecs[11] = '{32'hFFD8,  32'h0,  1'b1, 1'b0, 32'h99,       4'h0, 32'h0,        1'b0, 1'b0, 4'h0, 32'hA5};
    vecs[12] = '{32'hFFE0,  32'h0,  1'b1, 1'b0, 32'h99,       4'h0, 32'h99,       1'b1, 1'b0, 4'h0, 32'hA5};
    vecs[13] = '{32'hFFC2,  32'h0,  1'b1, 1'b0, 32'h77,       4'h0, 32'h77,       1'b1, 1'b0, 4'h0, 32'hA5};
    vecs[14] = '{32'hFFBC,  32'h9,  1'b0, 1'b1, 32'h1,        4'h0, 32'h1,        1'b0, 1'b1, 4'h0, 32'hA5};

    // Reset
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("reset_dev_start", 64'(dev_start), 64'h0);
    chk("reset_irq", 64'(irq), 64'h0);

    // Vector table: each row is one clock cycle
    for (int r = 0; r < 15; r++) begin
      cpu_addr   = vecs[r].addr;
      cpu_wdata  = vecs[r].wdata;
      cpu_read   = vecs[r].rd;
      cpu_write  = vecs[r].wr;
      mem_rdata  = vecs[r].mrd;
      dev_finish = vecs[r].fin;
      #1;
      chk($sformatf("v%0d_rdata", r), 64'(cpu_rdata), 64'(vecs[r].e_rdata));
      chk($sformatf("v%0d_mem_read", r), 64'(mem_read), 64'(vecs[r].e_mr));
      chk($sformatf("v%0d_mem_write", r), 64'(mem_write), 64'(vecs[r].e_mw));
      chk($sformatf("v%0d_dev_start", r), 64'(dev_start), 64'(vecs[r].e_start));
      chk($sformatf("v%0d_dev_data0", r), 64'(dev_data[31:0]), 64'(vecs[r].e_dd0));
      cyc();
    end
    cpu_read = 1'b0; cpu_write = 1'b0; dev_finish = '0; mem_rdata = '0; cpu_addr = 32'h100;

    // Channel 1 overflow: five stores fill dispatch + queue, sixth overflows
    for (int i = 0; i < 5; i++) store(32'hFFC8, 32'h11 + i);
    rd(32'hFFCC, rv);
    chk("ovf_full_status", 64'(rv), 64'h0403);
    chk("ovf_first_dispatched", 64'(dev_data[63:32]), 64'h11);
    store(32'hFFC8, 32'h16);
    rd(32'hFFCC, rv);
    chk("ovf_set_status", 64'(rv), 64'h040B);
    store(32'hFFCC, 32'h08);
    rd(32'hFFCC, rv);
    chk("ovf_clear_status", 64'(rv), 64'h0403);
    // Finish, then push on full during the START cycle: rejected despite the pop
    dev_finish = 4'h2;
    cyc();
    dev_finish = '0;
    cyc();
    chk("ovf_start_pulse", 64'(dev_start), 64'h2);
    chk("ovf_second_word", 64'(dev_data[63:32]), 64'h12);
    store(32'hFFC8, 32'h17);
    rd(32'hFFCC, rv);
    chk("ovf_push_pop_reject", 64'(rv), 64'h0319);

    // Channel 2 interrupt enable, clear, and set-vs-clear collision
    store(32'hFFD4, 32'h20);
    store(32'hFFD0, 32'h77);
    cyc();
    chk("irq_start_pulse", 64'(dev_start), 64'h4);
    chk("irq_start_data", 64'(dev_data[95:64]), 64'h77);
    cyc();
    dev_finish = 4'h4;
    cyc();
    dev_finish = '0;
    chk("irq_raised", 64'(irq), 64'h1);
    rd(32'hFFD4, rv);
    chk("irq_status_done", 64'(rv), 64'h34);
    store(32'hFFD4, 32'h30);
    chk("irq_cleared", 64'(irq), 64'h0);
    rd(32'hFFD4, rv);
    chk("irq_status_cleared", 64'(rv), 64'h24);
    store(32'hFFD0, 32'h78);
    cyc();
    cyc();
    cpu_addr = 32'hFFD4; cpu_wdata = 32'h30; cpu_write = 1'b1; dev_finish = 4'h4;
    cyc();
    cpu_write = 1'b0; dev_finish = '0;
    chk("irq_set_wins", 64'(irq), 64'h1);
    rd(32'hFFD4, rv);
    chk("irq_set_wins_status", 64'(rv), 64'h34);

    // Channels 0 and 3 interleaved, eight commands each so both FIFOs wrap
    t0 = -1; t3 = -1; n0 = 0; n3 = 0; spur = 0;
    for (int c = 0; c < 80; c++) begin
      cpu_write  = 1'b0;
      dev_finish = '0;
      if (c < 8 || (c >= 24 && c < 32)) begin
        k = (c < 8) ? c : c - 16;
        cpu_write = 1'b1;
        if (k % 2 == 0) begin
          cpu_addr  = 32'hFFC0;
          cpu_wdata = 32'hA000 + k;
          q0.push_back(32'hA000 + k);
        end else begin
          cpu_addr  = 32'hFFD8;
          cpu_wdata = 32'hB000 + k;
          q3.push_back(32'hB000 + k);
        end
      end
      if (t0 > 0) t0--;
      if (t0 == 0) begin dev_finish[0] = 1'b1; t0 = -1; end
      if (t3 > 0) t3--;
      if (t3 == 0) begin dev_finish[3] = 1'b1; t3 = -1; end
      #1;
      if (dev_start[0]) begin
        n0++;
        if (q0.size() == 0) chk("il_ch0_unexpected_start", 64'h1, 64'h0);
        else chk("il_ch0_order", 64'(dev_data[31:0]), 64'(q0.pop_front()));
        t0 = 1;
      end
      if (dev_start[3]) begin
        n3++;
        if (q3.size() == 0) chk("il_ch3_unexpected_start", 64'h1, 64'h0);
        else chk("il_ch3_order", 64'(dev_data[127:96]), 64'(q3.pop_front()));
        t3 = 3;
      end
      if (dev_start[1] | dev_start[2]) spur++;
      cyc();
    end
    cpu_write = 1'b0; dev_finish = '0;
    chk("il_ch0_count", 64'(n0), 64'd8);
    chk("il_ch3_count", 64'(n3), 64'd8);
    chk("il_spurious_starts", 64'(spur), 64'd0);
    rd(32'hFFC4, rv);
    chk("il_ch0_status", 64'(rv), 64'h14);
    rd(32'hFFDC, rv);
    chk("il_ch3_status", 64'(rv), 64'h14);

    // Reset while channel 0 is busy with two commands queued
    store(32'hFFC0, 32'h1);
    store(32'hFFC0, 32'h2);
    store(32'hFFC0, 32'h3);
    rd(32'hFFC4, rv);
    chk("rst_pre_status0", 64'(rv), 64'h0211);
    chk("rst_pre_irq", 64'(irq), 64'h1);
    rst_n = 1'b0;
    dev_finish = 4'hF;
    cyc();
    for (int i = 0; i < NDEV; i++) begin
      rd(BASE + 32'(8 * i + 4), rv);
      chk($sformatf("rst_status%0d", i), 64'(rv), 64'h04);
    end
    chk("rst_dev_start", 64'(dev_start), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_dev_data_lo", dev_data[63:0], 64'h0);
    chk("rst_dev_data_hi", dev_data[127:64], 64'h0);
    dev_finish = '0;
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("rst_no_redispatch", 64'(dev_start), 64'h0);
    rd(32'hFFC4, rv);
    chk("rst_post_status0", 64'(rv), 64'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
